// File: rtl/audio_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : audio_stream_fifo
// Purpose  : Single-clock BRAM-backed circular sample FIFO with valid/ready on
//            both sides, a two-entry output skid, a selectable underrun policy
//            and optional statistics (macro AUDIO_STREAM_FIFO_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module audio_stream_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 2048,
    parameter int UNDERRUN_MODE = 0,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  wr_valid_in,
    output logic                  wr_ready_out,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    input  logic                  rd_ready_in,
    output logic                  underrun_out,
    output logic [CW-1:0]         count_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic                  overflow_out
`ifdef AUDIO_STREAM_FIFO_STATS_EN
    ,
    output logic [CW-1:0]         max_count_out,
    output logic [15:0]           overflow_cnt_out
`endif
);

    localparam int              c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [CW-1:0]   c_depth    = CW'(DEPTH);
    localparam bit              c_repeat   = (UNDERRUN_MODE == 1);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [CW-1:0]         r_ram_cnt;
    logic [CW-1:0]         r_count;
    logic                  r_fetch_vld;
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic [DATA_WIDTH-1:0] r_skid0;
    logic [DATA_WIDTH-1:0] r_skid1;
    logic [1:0]            r_skid_cnt;
    logic [DATA_WIDTH-1:0] r_last;
    logic                  r_live;
    logic                  r_rep_stall;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_real_vld;
    logic [DATA_WIDTH-1:0] w_real_data;
    logic                  w_show_rep;
    logic                  w_pop;
    logic [2:0]            w_held;
    logic                  w_fetch;
    logic [CW-1:0]         w_count_nxt;
    logic [DATA_WIDTH-1:0] w_skid0_nxt;
    logic [DATA_WIDTH-1:0] w_skid1_nxt;

    assign w_full      = (r_count == c_depth);
    assign w_wr_acc    = wr_valid_in && !w_full && !flush_in;
    assign w_real_vld  = (r_skid_cnt != 2'd0) || r_fetch_vld;
    assign w_real_data = (r_skid_cnt != 2'd0) ? r_skid0 : r_ram_q;
    // A stalled repeat beat stays a repeat until taken, even if real data lands.
    assign w_show_rep  = c_repeat && r_live && (!w_real_vld || r_rep_stall);
    assign w_pop       = rd_ready_in && w_real_vld && !w_show_rep && !flush_in;
    assign w_held      = {1'b0, r_skid_cnt} + {2'b00, r_fetch_vld} - {2'b00, w_pop};
    assign w_fetch     = !flush_in && (r_ram_cnt != '0) && (w_held < 3'd2);
    assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_pop);

    always_comb begin
        w_skid0_nxt = r_skid0;
        w_skid1_nxt = r_skid1;
        if (w_pop) begin
            w_skid0_nxt = (r_skid_cnt == 2'd2) ? r_skid1 : r_ram_q;
            w_skid1_nxt = r_ram_q;
        end else begin
            if (r_skid_cnt == 2'd0) w_skid0_nxt = r_ram_q;
            if (r_skid_cnt != 2'd2) w_skid1_nxt = r_ram_q;
        end
    end

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (w_wr_acc) r_mem[r_head] <= wr_data_in;
        if (w_fetch)  r_ram_q       <= r_mem[r_tail];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_ram_cnt   <= '0;
            r_count     <= '0;
            r_fetch_vld <= 1'b0;
            r_skid0     <= '0;
            r_skid1     <= '0;
            r_skid_cnt  <= 2'd0;
            r_last      <= '0;
            r_live      <= 1'b0;
            r_rep_stall <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (flush_in) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_ram_cnt   <= '0;
            r_count     <= '0;
            r_fetch_vld <= 1'b0;
            r_skid0     <= '0;
            r_skid1     <= '0;
            r_skid_cnt  <= 2'd0;
            r_last      <= '0;
            r_live      <= 1'b1;
            r_rep_stall <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_overflow  <= wr_valid_in && w_full;
            r_rep_stall <= w_show_rep && !rd_ready_in;
            r_count     <= w_count_nxt;
            r_ram_cnt   <= r_ram_cnt + CW'(w_wr_acc) - CW'(w_fetch);
            r_fetch_vld <= w_fetch;
            r_skid_cnt  <= w_held[1:0];
            r_skid0     <= w_skid0_nxt;
            r_skid1     <= w_skid1_nxt;
            if (w_wr_acc) r_head <= (r_head == c_last_ptr) ? '0 : r_head + 1'b1;
            if (w_fetch)  r_tail <= (r_tail == c_last_ptr) ? '0 : r_tail + 1'b1;
            if (w_pop)    r_last <= w_real_data;
        end
    end

`ifdef AUDIO_STREAM_FIFO_STATS_EN
    logic [CW-1:0] r_max_count;
    logic [15:0]   r_ovf_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_max_count <= '0;
            r_ovf_cnt   <= '0;
        end else if (flush_in) begin
            r_max_count <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            if (w_count_nxt > r_max_count) r_max_count <= w_count_nxt;
            if (wr_valid_in && w_full && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign max_count_out    = r_max_count;
    assign overflow_cnt_out = r_ovf_cnt;
`endif

    assign wr_ready_out = !w_full;
    assign count_out    = r_count;
    assign full_out     = w_full;
    assign empty_out    = (r_count == '0);
    assign overflow_out = r_overflow;
    assign rd_valid_out = (c_repeat && r_live) || w_real_vld;
    assign underrun_out = w_show_rep;
    assign rd_data_out  = (w_real_vld && !w_show_rep) ? w_real_data : r_last;

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_stream_fifo
// Purpose  : Self-checking bench; two instances (DEPTH=5 stall mode, DEPTH=8
//            repeat mode) share random stimulus and a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_stream_fifo;

    localparam int DW  = 16;
    localparam int D0  = 5;
    localparam int D1  = 8;
    localparam int CW0 = $clog2(D0 + 1);
    localparam int CW1 = $clog2(D1 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          rd_ready;

    logic [DW-1:0]  rd_data0, rd_data1;
    logic           rd_valid0, rd_valid1, wr_ready0, wr_ready1;
    logic           underrun0, underrun1, full0, full1, empty0, empty1, ovf0, ovf1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;
`ifdef AUDIO_STREAM_FIFO_STATS_EN
    logic [CW0-1:0] mx0;
    logic [CW1-1:0] mx1;
    logic [15:0]    oc0, oc1;
`endif

    audio_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(D0), .UNDERRUN_MODE(0)) u_dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .wr_data_in(wr_data), .wr_valid_in(wr_valid), .wr_ready_out(wr_ready0),
        .rd_data_out(rd_data0), .rd_valid_out(rd_valid0), .rd_ready_in(rd_ready),
        .underrun_out(underrun0), .count_out(cnt0), .full_out(full0),
        .empty_out(empty0), .overflow_out(ovf0)
`ifdef AUDIO_STREAM_FIFO_STATS_EN
        , .max_count_out(mx0), .overflow_cnt_out(oc0)
`endif
    );

    audio_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(D1), .UNDERRUN_MODE(1)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .wr_data_in(wr_data), .wr_valid_in(wr_valid), .wr_ready_out(wr_ready1),
        .rd_data_out(rd_data1), .rd_valid_out(rd_valid1), .rd_ready_in(rd_ready),
        .underrun_out(underrun1), .count_out(cnt1), .full_out(full1),
        .empty_out(empty1), .overflow_out(ovf1)
`ifdef AUDIO_STREAM_FIFO_STATS_EN
        , .max_count_out(mx1), .overflow_cnt_out(oc1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per instance, a FIFO of (data, accept cycle).
    int m_data [2][64];
    int m_time [2][64];
    int m_rd   [2];
    int m_wr   [2];
    int m_last [2];
    int m_ovf  [2];
    int m_stall[2];
    int m_max  [2];
    int m_ovfc [2];
    bit m_live;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_rd[d] = 0; m_wr[d] = 0; m_last[d] = 0; m_ovf[d] = 0;
            m_stall[d] = 0; m_max[d] = 0; m_ovfc[d] = 0;
        end
        m_live = 1'b0;
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? D0 : D1;
    endfunction

    // Head is presentable once it was accepted at least two cycles ago.
    task automatic view(input int d, output bit vis, output bit rep);
        int size;
        size = m_wr[d] - m_rd[d];
        vis  = (size > 0) && (m_time[d][m_rd[d] % 64] + 2 <= cyc);
        rep  = (d == 1) && m_live && (!vis || (m_stall[d] != 0));
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            bit vis, rep, ev;
            int size, dep;
            logic [31:0] o_data, o_cnt;
            logic o_valid, o_under, o_full, o_empty, o_rdy, o_ovf;
            string p;
            view(d, vis, rep);
            size = m_wr[d] - m_rd[d];
            dep  = depth_of(d);
            ev   = vis || rep;
            p    = (d == 0) ? "m0" : "m1";
            o_data  = (d == 0) ? 32'(rd_data0)  : 32'(rd_data1);
            o_cnt   = (d == 0) ? 32'(cnt0)      : 32'(cnt1);
            o_valid = (d == 0) ? rd_valid0 : rd_valid1;
            o_under = (d == 0) ? underrun0 : underrun1;
            o_full  = (d == 0) ? full0     : full1;
            o_empty = (d == 0) ? empty0    : empty1;
            o_rdy   = (d == 0) ? wr_ready0 : wr_ready1;
            o_ovf   = (d == 0) ? ovf0      : ovf1;
            check({p, ".rd_valid"}, 32'(o_valid), 32'(ev));
            check({p, ".underrun"}, 32'(o_under), 32'(rep));
            if (ev)
                check({p, ".rd_data"}, o_data, rep ? 32'(m_last[d]) : 32'(m_data[d][m_rd[d] % 64]));
            else if (!m_live)
                check({p, ".rd_data_rst"}, o_data, 32'd0);
            check({p, ".count"},    o_cnt,          32'(size));
            check({p, ".full"},     32'(o_full),    32'(size == dep));
            check({p, ".empty"},    32'(o_empty),   32'(size == 0));
            check({p, ".wr_ready"}, 32'(o_rdy),     32'(size < dep));
            check({p, ".overflow"}, 32'(o_ovf),     32'(m_ovf[d]));
`ifdef AUDIO_STREAM_FIFO_STATS_EN
            check({p, ".max_count"}, (d == 0) ? 32'(mx0) : 32'(mx1), 32'(m_max[d]));
            check({p, ".ovf_cnt"},   (d == 0) ? 32'(oc0) : 32'(oc1), 32'(m_ovfc[d]));
`endif
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit vis, rep;
            int size;
            view(d, vis, rep);
            size = m_wr[d] - m_rd[d];
            if (flush) begin
                m_rd[d] = m_wr[d]; m_last[d] = 0; m_ovf[d] = 0;
                m_stall[d] = 0; m_max[d] = 0; m_ovfc[d] = 0;
            end else begin
                m_ovf[d]   = (wr_valid && size == depth_of(d)) ? 1 : 0;
                if (m_ovf[d] != 0 && m_ovfc[d] < 65535) m_ovfc[d]++;
                m_stall[d] = (rep && !rd_ready) ? 1 : 0;
                if (rd_ready && vis && !rep) begin
                    m_last[d] = m_data[d][m_rd[d] % 64];
                    m_rd[d]++;
                end
                if (wr_valid && size < depth_of(d)) begin
                    m_data[d][m_wr[d] % 64] = int'(wr_data);
                    m_time[d][m_wr[d] % 64] = cyc;
                    m_wr[d]++;
                end
                if (m_wr[d] - m_rd[d] > m_max[d]) m_max[d] = m_wr[d] - m_rd[d];
            end
        end
        m_live = 1'b1;
        cyc++;
    endtask

    task automatic tick(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
        wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic random_run(input int n, input int p_wr, input int p_rd, input int p_fl);
        for (int i = 0; i < n; i++)
            tick($urandom_range(0, 99) < p_wr, DW'($urandom), $urandom_range(0, 99) < p_rd,
                 $urandom_range(0, 999) < p_fl);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single sample latency.
        tick(1, 16'h0011, 1, 0);
        repeat (4) tick(0, 16'h0, 1, 0);

        // Fill past full with the reader stalled, then drain.
        for (int i = 1; i <= 10; i++) tick(1, DW'(i), 0, 0);
        repeat (14) tick(0, 16'h0, 1, 0);

        // Sustained one beat per cycle.
        for (int i = 0; i < 23; i++) tick(1, DW'(16'h100 + i), 1, 0);
        repeat (4) tick(0, 16'h0, 1, 0);

        // Backpressure pattern 1,0,0,1.
        for (int i = 0; i < 40; i++) tick(i < 20, DW'(16'h200 + i), (i % 4 == 0) || (i % 4 == 3), 0);
        repeat (20) tick(0, 16'h0, (cyc % 4 == 0) || (cyc % 4 == 3), 0);

        // Repeat-last-sample behaviour.
        tick(1, 16'h0007, 1, 0);
        repeat (5) tick(0, 16'h0, 1, 0);
        tick(1, 16'h0009, 1, 0);
        repeat (4) tick(0, 16'h0, 1, 0);

        // Flush with stored data and a simultaneous write.
        for (int i = 0; i < 4; i++) tick(1, DW'(16'h300 + i), 0, 0);
        tick(1, 16'h0333, 1, 1);
        repeat (3) tick(0, 16'h0, 1, 0);

        random_run(300, 60, 65, 10);
        random_run(200, 85, 30, 5);
        random_run(200, 30, 90, 20);

        // Asynchronous reset in the middle of traffic.
        #2 rst_n = 1'b0;
        #1 reset_model();
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        random_run(300, 55, 55, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
